store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/params_pkg.sv | 16 +
 rtl/store_unit_fifo.sv | 76 +++++++
 rtl/store_unit.sv | 112 +++++++++++
 tb/tb_store_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared definitions for the store unit.
//   SIZE_B/SIZE_H/SIZE_W : bit positions of the one-hot store size input
//   store_entry_t        : one buffered write {word address, lane data, byte strobe}
package params_pkg;

  localparam int SIZE_B = 0;
  localparam int SIZE_H = 1;
  localparam int SIZE_W = 2;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } store_entry_t;

endpackage

// File: rtl/store_unit_fifo.sv
// store_fifo: circular store buffer of DEPTH entries (DEPTH a power of two, >= 2).
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push_i, push_entry_i : enqueue an entry (caller guarantees not full)
//   pop_i                : dequeue the head (caller guarantees not empty)
//   head_o               : entry at the read pointer
//   full_o, empty_o      : occupancy flags
//   entry_valid_o        : per-slot occupancy, for the load hazard compare
//   entry_addr_o         : per-slot word address, for the load hazard compare
module store_fifo
  import params_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  store_entry_t             push_entry_i,
  input  logic                     pop_i,
  output store_entry_t             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DEPTH-1:0]         entry_valid_o,
  output logic [DEPTH-1:0][29:0]   entry_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Payload carries no reset: occupancy is tracked only by pointers and count.
  store_entry_t mem_q [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the current count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] rel;
      assign rel               = PTR_W'(gi) - rd_ptr_q;
      assign entry_valid_o[gi] = (CNT_W'(rel) < count_q);
      assign entry_addr_o[gi]  = mem_q[gi].addr;
    end
  endgenerate

endmodule

// File: rtl/store_unit.sv
// store_unit: formats pipeline stores into lane-positioned, strobed word writes,
// buffers them in FIFO order and drains them to data memory.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   mem_size_onehot          : store size, bit0 byte / bit1 half / bit2 word
//   req_valid_i/req_ready_o  : store request handshake
//   waddr_i, wdata_unformatted_i : byte address and LSB-aligned store data
//   misaligned_store_o       : current request is misaligned (not buffered)
//   mem_w*                   : write channel toward data memory (head of buffer)
//   load_check_i, load_addr_i, load_hazard_o : load-vs-buffered-store word overlap
//   empty_o                  : no buffered stores
module store_unit
  import params_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  mem_size_onehot,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_unformatted_i,
  output logic        misaligned_store_o,
  output logic        mem_wvalid_o,
  input  logic        mem_wready_i,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        load_check_i,
  input  logic [31:0] load_addr_i,
  output logic        load_hazard_o,
  output logic        empty_o
);

  logic [1:0]  off;
  logic        size_valid;
  logic        misaligned;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;

  logic                   fifo_full, fifo_empty, push, pop, hazard;
  store_entry_t           push_entry, head;
  logic [DEPTH-1:0]       entry_valid;
  logic [DEPTH-1:0][29:0] entry_addr;
  logic [1:0]             load_off_unused;

  assign off = waddr_i[1:0];

  // Lowest set size bit wins; an all-zero size is accepted and dropped.
  always_comb begin
    size_valid = 1'b1;
    misaligned = 1'b0;
    fmt_strb   = 4'h0;
    fmt_data   = 32'h0;
    if (mem_size_onehot[SIZE_B]) begin
      fmt_strb = 4'h1 << off;
      fmt_data = {24'b0, wdata_unformatted_i[7:0]} << {off, 3'b000};
    end else if (mem_size_onehot[SIZE_H]) begin
      fmt_strb   = 4'h3 << {off[1], 1'b0};
      fmt_data   = {16'b0, wdata_unformatted_i[15:0]} << {off[1], 4'b0000};
      misaligned = off[0];
    end else if (mem_size_onehot[SIZE_W]) begin
      fmt_strb   = 4'hF;
      fmt_data   = wdata_unformatted_i;
      misaligned = (off != 2'b00);
    end else begin
      size_valid = 1'b0;
    end
  end

  assign misaligned_store_o = misaligned && req_valid_i;
  assign req_ready_o        = !fifo_full;

  // Misaligned or sizeless requests still complete the handshake but are dropped.
  assign push = req_valid_i && req_ready_o && size_valid && !misaligned;
  assign pop  = mem_wvalid_o && mem_wready_i;

  assign push_entry = '{addr: waddr_i[31:2], data: fmt_data, strb: fmt_strb};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .head_o        (head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  assign mem_wvalid_o = !fifo_empty;
  assign mem_waddr_o  = {head.addr, 2'b00};
  assign mem_wdata_o  = head.data;
  assign mem_wstrb_o  = head.strb;
  assign empty_o      = fifo_empty;

  // Compares buffered entries only (head included); the incoming request is not
  // yet in the buffer and so is never seen here.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == load_addr_i[31:2])) hazard = 1'b1;
    end
  end

  assign load_hazard_o   = load_check_i && hazard;
  assign load_off_unused = load_addr_i[1:0];

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [2:0]  mem_size_onehot;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] waddr_i;
  logic [31:0] wdata_unformatted_i;
  logic        misaligned_store_o;
  logic        mem_wvalid_o;
  logic        mem_wready_i;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        load_check_i;
  logic [31:0] load_addr_i;
  logic        load_hazard_o;
  logic        empty_o;

  store_unit #(.DEPTH(4)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .mem_size_onehot     (mem_size_onehot),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .waddr_i             (waddr_i),
    .wdata_unformatted_i (wdata_unformatted_i),
    .misaligned_store_o  (misaligned_store_o),
    .mem_wvalid_o        (mem_wvalid_o),
    .mem_wready_i        (mem_wready_i),
    .mem_waddr_o         (mem_waddr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_wstrb_o         (mem_wstrb_o),
    .load_check_i        (load_check_i),
    .load_addr_i         (load_addr_i),
    .load_hazard_o       (load_hazard_o),
    .empty_o             (empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  typedef struct {
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
    logic        push;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  estrb;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   writes_seen = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endfunction

  // Write monitor: every accepted memory write is checked against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && mem_wvalid_o === 1'b1 && mem_wready_i === 1'b1) begin
      exp_t e;
      writes_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_waddr_o, mem_wdata_o);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem_waddr_o, e.addr);
        chk("wr_data", mem_wdata_o, e.data);
        chk("wr_strb", 32'(mem_wstrb_o), 32'(e.strb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    mem_size_onehot     = sz;
    waddr_i             = a;
    wdata_unformatted_i = d;
    req_valid_i         = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  vec_t vecs[11];
  int   base_writes;

  initial begin
    vecs[0]  = '{3'b001, 32'h1003, 32'hAABBCCDD, 1'b0, 1'b1, 32'h1000, 32'hDD000000, 4'h8};
    vecs[1]  = '{3'b001, 32'h1000, 32'h11223344, 1'b0, 1'b1, 32'h1000, 32'h00000044, 4'h1};
    vecs[2]  = '{3'b010, 32'h2002, 32'h0000BEEF, 1'b0, 1'b1, 32'h2000, 32'hBEEF0000, 4'hC};
    vecs[3]  = '{3'b010, 32'h2000, 32'h12345678, 1'b0, 1'b1, 32'h2000, 32'h00005678, 4'h3};
    vecs[4]  = '{3'b010, 32'h2001, 32'h12345678, 1'b1, 1'b0, 32'h0,    32'h0,        4'h0};
    vecs[5]  = '{3'b100, 32'h4000, 32'hDEADBEEF, 1'b0, 1'b1, 32'h4000, 32'hDEADBEEF, 4'hF};
    vecs[6]  = '{3'b100, 32'h4002, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,    32'h0,        4'h0};
    vecs[7]  = '{3'b000, 32'h4004, 32'h01020304, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0};
    vecs[8]  = '{3'b011, 32'h5001, 32'h000000AB, 1'b0, 1'b1, 32'h5000, 32'h0000AB00, 4'h2};
    vecs[9]  = '{3'b110, 32'h6002, 32'h0000CAFE, 1'b0, 1'b1, 32'h6000, 32'hCAFE0000, 4'hC};
    vecs[10] = '{3'b110, 32'h6003, 32'h0000CAFE, 1'b1, 1'b0, 32'h0,    32'h0,        4'h0};

    rst_ni = 1'b0;
    mem_size_onehot = 3'b000;
    req_valid_i = 1'b0;
    waddr_i = '0;
    wdata_unformatted_i = '0;
    mem_wready_i = 1'b1;
    load_check_i = 1'b1;
    load_addr_i = 32'h0;

    // Reset state
    @(negedge clk_i);
    chk("rst_wvalid", 32'(mem_wvalid_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_hazard", 32'(load_hazard_o), 32'd0);
    rst_ni = 1'b1;
    load_check_i = 1'b0;
    step();

    // Formatting vectors, memory always ready
    for (int i = 0; i < 11; i++) begin
      set_req(vecs[i].sz, vecs[i].addr, vecs[i].data);
      if (vecs[i].push) sb.push_back('{vecs[i].eaddr, vecs[i].edata, vecs[i].estrb});
      @(negedge clk_i);
      chk($sformatf("v%0d_mis", i), 32'(misaligned_store_o), 32'(vecs[i].mis));
      step();
      req_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'd1);
      chk($sformatf("v%0d_sb", i), 32'(sb.size()), 32'd0);
      step();
    end

    // Fill to capacity with memory stalled
    mem_wready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(3'b100, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      sb.push_back('{32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF});
      @(negedge clk_i);
      chk($sformatf("fill%0d_ready", i), 32'(req_ready_o), 32'd1);
      step();
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("full_ready", 32'(req_ready_o), 32'd0);
    chk("full_wvalid", 32'(mem_wvalid_o), 32'd1);
    chk("stall_addr0", mem_waddr_o, 32'h100);
    step();
    @(negedge clk_i);
    chk("stall_addr1", mem_waddr_o, 32'h100);
    chk("stall_data1", mem_wdata_o, 32'hA0);
    // 5th store refused, including in the cycle the head drains
    set_req(3'b100, 32'h110, 32'hA4);
    @(negedge clk_i);
    chk("fifth_ready", 32'(req_ready_o), 32'd0);
    step();
    mem_wready_i = 1'b1;
    @(negedge clk_i);
    chk("drain_ready", 32'(req_ready_o), 32'd0);
    step();
    mem_wready_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("after_drain_ready", 32'(req_ready_o), 32'd1);
    chk("after_drain_head", mem_waddr_o, 32'h104);
    step();
    mem_wready_i = 1'b1;
    repeat (4) step();
    @(negedge clk_i);
    chk("fill_empty", 32'(empty_o), 32'd1);
    chk("fill_sb", 32'(sb.size()), 32'd0);
    step();

    // Load hazard
    mem_wready_i = 1'b0;
    set_req(3'b100, 32'h3000, 32'h33);
    sb.push_back('{32'h3000, 32'h33, 4'hF});
    step();
    req_valid_i = 1'b0;
    load_check_i = 1'b1;
    load_addr_i = 32'h3002;
    @(negedge clk_i);
    chk("hz_same_word", 32'(load_hazard_o), 32'd1);
    load_addr_i = 32'h3004;
    #1;
    chk("hz_next_word", 32'(load_hazard_o), 32'd0);
    load_check_i = 1'b0;
    load_addr_i = 32'h3000;
    #1;
    chk("hz_no_check", 32'(load_hazard_o), 32'd0);
    step();
    load_check_i = 1'b1;
    load_addr_i = 32'h7000;
    set_req(3'b100, 32'h7000, 32'h77);
    sb.push_back('{32'h7000, 32'h77, 4'hF});
    @(negedge clk_i);
    chk("hz_incoming", 32'(load_hazard_o), 32'd0);
    step();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("hz_buffered", 32'(load_hazard_o), 32'd1);
    step();
    load_addr_i = 32'h3001;
    mem_wready_i = 1'b1;
    @(negedge clk_i);
    chk("hz_head_writing", 32'(load_hazard_o), 32'd1);
    step();
    load_check_i = 1'b0;
    repeat (2) step();
    @(negedge clk_i);
    chk("hz_empty", 32'(empty_o), 32'd1);
    step();

    // Reset with a write mid-handshake and three entries held
    mem_wready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(3'b100, 32'h9000 + 32'(4 * i), 32'h90 + 32'(i));
      step();
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_wvalid", 32'(mem_wvalid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_wvalid", 32'(mem_wvalid_o), 32'd0);
    chk("async_rst_empty", 32'(empty_o), 32'd1);
    chk("async_rst_ready", 32'(req_ready_o), 32'd1);
    sb.delete();
    base_writes = writes_seen;
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_wready_i = 1'b1;
    repeat (3) step();
    @(negedge clk_i);
    chk("post_rst_writes", 32'(writes_seen - base_writes), 32'd0);
    chk("post_rst_empty", 32'(empty_o), 32'd1);
    step();

    // Back-to-back stream, memory always ready; wraps pointers several times
    base_writes = writes_seen;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] d;
      d = $urandom;
      set_req(3'b100, 32'h8000 + 32'(4 * i), d);
      sb.push_back('{32'h8000 + 32'(4 * i), d, 4'hF});
      @(negedge clk_i);
      if (i > 0) begin
        chk($sformatf("st%0d_wvalid", i), 32'(mem_wvalid_o), 32'd1);
        chk($sformatf("st%0d_ready", i), 32'(req_ready_o), 32'd1);
      end
      step();
    end
    req_valid_i = 1'b0;
    repeat (2) step();
    @(negedge clk_i);
    chk("stream_writes", 32'(writes_seen - base_writes), 32'd12);
    chk("stream_sb", 32'(sb.size()), 32'd0);
    chk("stream_empty", 32'(empty_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
